// File: rtl/ir_pipeline_ctrl.sv
// ir_pipeline_ctrl: instruction-register pipeline and hazard control for a 5-stage core.
//
// Holds the F/D, D/X, X/M and M/W instruction registers. Each edge it takes one action,
// highest priority first:
//   1. mul/div hold - the op in D/X waits for the multiplier/divider.
//   2. branch flush - a taken branch/jump in X squashes F/D and D/X.
//   3. load-use stall - a bubble is inserted behind a load.
//   4. normal advance.
//
// Ports:
//   clk           - rising-edge clock for all state
//   rst_n         - asynchronous active-low reset
//   fetch_ir      - instruction fetched at the current PC
//   branch_taken  - X-stage branch/jump resolved taken
//   multdiv_ready - mul/div result valid (one-cycle pulse)
//   fd_ir, dx_ir, xm_ir, mw_ir - pipeline instruction registers
//   pc_enable     - PC and fd_ir may advance this cycle
//   multdiv_start - one-cycle pulse launching the mul/div held in dx_ir
//   md_busy       - mul/div in flight (waiting for multdiv_ready)
module ir_pipeline_ctrl #(
    parameter logic [31:0] NOP_IR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_ir,
    input  logic        branch_taken,
    input  logic        multdiv_ready,
    output logic [31:0] fd_ir,
    output logic [31:0] dx_ir,
    output logic [31:0] xm_ir,
    output logic [31:0] mw_ir,
    output logic        pc_enable,
    output logic        multdiv_start,
    output logic        md_busy
);

    typedef enum logic [1:0] {
        MdIdle  = 2'd0,
        MdStart = 2'd1,
        MdWait  = 2'd2
    } md_state_e;

    localparam logic [4:0] OpRtype = 5'b00000;
    localparam logic [4:0] OpJr    = 5'b00100;
    localparam logic [4:0] OpBex   = 5'b10110;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] OpBne   = 5'b00010;
    localparam logic [4:0] OpBlt   = 5'b00110;
    localparam logic [4:0] OpLw    = 5'b01000;
    localparam logic [4:0] AluMul  = 5'b00110;
    localparam logic [4:0] AluDiv  = 5'b00111;

    md_state_e   md_state_q, md_state_d;
    logic [31:0] fd_ir_q, fd_ir_d;
    logic [31:0] dx_ir_q, dx_ir_d;
    logic [31:0] xm_ir_q, xm_ir_d;
    logic [31:0] mw_ir_q, mw_ir_d;

    // Field decode
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic [4:0] fd_src_a, fd_src_b;
    logic       fd_src_b_used;
    logic       dx_is_md;
    logic       md_done;
    logic       md_hold;
    logic       load_use;

    assign fd_op  = fd_ir_q[31:27];
    assign fd_rd  = fd_ir_q[26:22];
    assign fd_rs  = fd_ir_q[21:17];
    assign fd_rt  = fd_ir_q[16:12];
    assign dx_op  = dx_ir_q[31:27];
    assign dx_rd  = dx_ir_q[26:22];
    assign dx_alu = dx_ir_q[6:2];

    assign dx_is_md = (dx_op == OpRtype) && ((dx_alu == AluMul) || (dx_alu == AluDiv));
    assign md_done  = (md_state_q == MdWait) && multdiv_ready;
    assign md_hold  = dx_is_md && !md_done;

    always_comb begin
        fd_src_a      = fd_rs;
        fd_src_b      = fd_rt;
        fd_src_b_used = 1'b0;
        if (fd_op == OpJr) begin
            fd_src_a = fd_rd;
        end else if (fd_op == OpBex) begin
            fd_src_a = 5'd30;
        end
        if (fd_op == OpRtype) begin
            fd_src_b_used = 1'b1;
        end else if ((fd_op == OpBne) || (fd_op == OpBlt)) begin
            fd_src_b      = fd_rd;
            fd_src_b_used = 1'b1;
        end
        // Store data (sw rd) is left out: the W->M bypass supplies it in time.
    end

    assign load_use = (dx_op == OpLw) && (dx_rd != 5'd0) &&
                      ((dx_rd == fd_src_a) || (fd_src_b_used && (dx_rd == fd_src_b)));

    always_comb begin
        md_state_d = md_state_q;
        unique case (md_state_q)
            MdIdle:  if (dx_is_md) md_state_d = MdStart;
            MdStart: md_state_d = MdWait;
            MdWait:  if (multdiv_ready) md_state_d = MdIdle;
            default: md_state_d = MdIdle;
        endcase
    end

    always_comb begin
        fd_ir_d = fetch_ir;
        dx_ir_d = fd_ir_q;
        xm_ir_d = dx_ir_q;
        mw_ir_d = xm_ir_q;
        if (md_hold) begin
            fd_ir_d = fd_ir_q;
            dx_ir_d = dx_ir_q;
            xm_ir_d = NOP_IR;
        end else if (branch_taken) begin
            fd_ir_d = NOP_IR;
            dx_ir_d = NOP_IR;
        end else if (load_use) begin
            fd_ir_d = fd_ir_q;
            dx_ir_d = NOP_IR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_state_q <= MdIdle;
            fd_ir_q    <= NOP_IR;
            dx_ir_q    <= NOP_IR;
            xm_ir_q    <= NOP_IR;
            mw_ir_q    <= NOP_IR;
        end else begin
            md_state_q <= md_state_d;
            fd_ir_q    <= fd_ir_d;
            dx_ir_q    <= dx_ir_d;
            xm_ir_q    <= xm_ir_d;
            mw_ir_q    <= mw_ir_d;
        end
    end

    // A flush takes precedence over a load-use stall, so only an unflushed stall drops PC.
    assign pc_enable     = !rst_n || !(md_hold || (load_use && !branch_taken));
    assign multdiv_start = (md_state_q == MdStart);
    assign md_busy       = (md_state_q == MdWait);
    assign fd_ir         = fd_ir_q;
    assign dx_ir         = dx_ir_q;
    assign xm_ir         = xm_ir_q;
    assign mw_ir         = mw_ir_q;

endmodule

// File: tb/tb_ir_pipeline_ctrl.sv
// Directed-vector bench for ir_pipeline_ctrl: straight-line flow, load-use stalls,
// branch flush, mul/div hold and reset during a mul/div wait.
module tb_ir_pipeline_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_ir;
    logic        branch_taken;
    logic        multdiv_ready;
    logic [31:0] fd_ir, dx_ir, xm_ir, mw_ir;
    logic        pc_enable, multdiv_start, md_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ir_pipeline_ctrl #(.NOP_IR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_ir     (fetch_ir),
        .branch_taken (branch_taken),
        .multdiv_ready(multdiv_ready),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .xm_ir        (xm_ir),
        .mw_ir        (mw_ir),
        .pc_enable    (pc_enable),
        .multdiv_start(multdiv_start),
        .md_busy      (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fetch;
        logic        br;
        logic        rdy;
        logic        pc;     // expected during the cycle, before the edge
        logic        st;
        logic        bz;
        logic [31:0] fd;     // expected after the edge
        logic [31:0] dx;
        logic [31:0] xm;
        logic [31:0] mw;
    } vec_t;

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [step %0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check combinational outputs, clock, check IRs.
    task automatic apply(input vec_t v, input int idx);
        fetch_ir      = v.fetch;
        branch_taken  = v.br;
        multdiv_ready = v.rdy;
        #3;
        check("pc_enable", idx, {31'd0, pc_enable}, {31'd0, v.pc});
        check("multdiv_start", idx, {31'd0, multdiv_start}, {31'd0, v.st});
        check("md_busy", idx, {31'd0, md_busy}, {31'd0, v.bz});
        @(posedge clk);
        #1;
        check("fd_ir", idx, fd_ir, v.fd);
        check("dx_ir", idx, dx_ir, v.dx);
        check("xm_ir", idx, xm_ir, v.xm);
        check("mw_ir", idx, mw_ir, v.mw);
    endtask

    logic [31:0] a_i, b_i, l_i, u_i, s_i, l0_i, u0_i, t_i, m_i;
    vec_t tbl[19];
    vec_t md[9];
    vec_t rs[5];

    initial begin
        a_i  = itype(5'b00101, 5'd1, 5'd0, 17'd5); // addi r1,r0,5
        b_i  = rtype(5'd2, 5'd1, 5'd1, 5'd0);      // add r2,r1,r1
        l_i  = itype(5'b01000, 5'd3, 5'd0, 17'd0); // lw r3,0(r0)
        u_i  = rtype(5'd4, 5'd3, 5'd0, 5'd0);      // add r4,r3,r0
        s_i  = itype(5'b00111, 5'd3, 5'd5, 17'd0); // sw r3,0(r5)
        l0_i = itype(5'b01000, 5'd0, 5'd1, 17'd0); // lw r0,0(r1)
        u0_i = rtype(5'd4, 5'd0, 5'd0, 5'd0);      // add r4,r0,r0
        t_i  = rtype(5'd4, 5'd0, 5'd3, 5'd0);      // add r4,r0,r3 (hazard on rt)
        m_i  = rtype(5'd5, 5'd1, 5'd2, 5'd6);      // mul r5,r1,r2

        //            fetch br  rdy pc  st  bz  fd    dx    xm    mw
        tbl[0]  = '{a_i,  0, 0, 1, 0, 0, a_i,  0,    0,    0};
        tbl[1]  = '{b_i,  0, 0, 1, 0, 0, b_i,  a_i,  0,    0};
        tbl[2]  = '{l_i,  0, 0, 1, 0, 0, l_i,  b_i,  a_i,  0};
        tbl[3]  = '{u_i,  0, 0, 1, 0, 0, u_i,  l_i,  b_i,  a_i};
        tbl[4]  = '{s_i,  0, 0, 0, 0, 0, u_i,  0,    l_i,  b_i};   // load-use stall
        tbl[5]  = '{s_i,  0, 0, 1, 0, 0, s_i,  u_i,  0,    l_i};
        tbl[6]  = '{l_i,  0, 0, 1, 0, 0, l_i,  s_i,  u_i,  0};
        tbl[7]  = '{s_i,  0, 0, 1, 0, 0, s_i,  l_i,  s_i,  u_i};
        tbl[8]  = '{l0_i, 0, 0, 1, 0, 0, l0_i, s_i,  l_i,  s_i};   // sw data: no stall
        tbl[9]  = '{u0_i, 0, 0, 1, 0, 0, u0_i, l0_i, s_i,  l_i};
        tbl[10] = '{a_i,  0, 0, 1, 0, 0, a_i,  u0_i, l0_i, s_i};   // lw r0: no stall
        tbl[11] = '{l_i,  0, 0, 1, 0, 0, l_i,  a_i,  u0_i, l0_i};
        tbl[12] = '{u_i,  0, 0, 1, 0, 0, u_i,  l_i,  a_i,  u0_i};
        tbl[13] = '{b_i,  1, 0, 1, 0, 0, 0,    0,    l_i,  a_i};   // flush beats load-use
        tbl[14] = '{b_i,  0, 0, 1, 0, 0, b_i,  0,    0,    l_i};
        tbl[15] = '{l_i,  0, 0, 1, 0, 0, l_i,  b_i,  0,    0};
        tbl[16] = '{t_i,  0, 0, 1, 0, 0, t_i,  l_i,  b_i,  0};
        tbl[17] = '{a_i,  0, 0, 0, 0, 0, t_i,  0,    l_i,  b_i};   // rt hazard stall
        tbl[18] = '{a_i,  0, 0, 1, 0, 0, a_i,  t_i,  0,    l_i};

        md[0] = '{m_i, 0, 0, 1, 0, 0, m_i, a_i, t_i, 0};
        md[1] = '{b_i, 0, 0, 1, 0, 0, b_i, m_i, a_i, t_i};
        md[2] = '{b_i, 0, 1, 0, 0, 0, b_i, m_i, 0,   a_i};  // ready ignored in idle
        md[3] = '{b_i, 0, 1, 0, 1, 0, b_i, m_i, 0,   0};    // start pulse, ready ignored
        md[4] = '{b_i, 0, 0, 0, 0, 1, b_i, m_i, 0,   0};
        md[5] = '{b_i, 1, 0, 0, 0, 1, b_i, m_i, 0,   0};    // branch ignored in hold
        md[6] = '{b_i, 0, 0, 0, 0, 1, b_i, m_i, 0,   0};
        md[7] = '{a_i, 0, 1, 1, 0, 1, a_i, b_i, m_i, 0};    // completion advance
        md[8] = '{a_i, 0, 0, 1, 0, 0, a_i, a_i, b_i, m_i};

        rs[0] = '{m_i, 0, 0, 1, 0, 0, m_i, a_i, a_i, b_i};
        rs[1] = '{b_i, 0, 0, 1, 0, 0, b_i, m_i, a_i, a_i};
        rs[2] = '{b_i, 0, 0, 0, 0, 0, b_i, m_i, 0,   a_i};
        rs[3] = '{b_i, 0, 0, 0, 1, 0, b_i, m_i, 0,   0};
        rs[4] = '{b_i, 0, 0, 0, 0, 1, b_i, m_i, 0,   0};

        rst_n         = 1'b0;
        fetch_ir      = 32'h0;
        branch_taken  = 1'b0;
        multdiv_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset fd_ir", 0, fd_ir, 32'h0);
        check("reset dx_ir", 0, dx_ir, 32'h0);
        check("reset xm_ir", 0, xm_ir, 32'h0);
        check("reset mw_ir", 0, mw_ir, 32'h0);
        check("reset pc_enable", 0, {31'd0, pc_enable}, 32'd1);
        check("reset multdiv_start", 0, {31'd0, multdiv_start}, 32'd0);
        check("reset md_busy", 0, {31'd0, md_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) apply(tbl[i], i);
        for (int i = 0; i < 9; i++) apply(md[i], 100 + i);
        for (int i = 0; i < 5; i++) apply(rs[i], 200 + i);

        // Now in the mul/div wait; reset mid-operation.
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-reset fd_ir", 300, fd_ir, 32'h0);
        check("mid-reset dx_ir", 300, dx_ir, 32'h0);
        check("mid-reset xm_ir", 300, xm_ir, 32'h0);
        check("mid-reset mw_ir", 300, mw_ir, 32'h0);
        check("mid-reset md_busy", 300, {31'd0, md_busy}, 32'd0);
        check("mid-reset pc_enable", 300, {31'd0, pc_enable}, 32'd1);
        #1;
        rst_n = 1'b1;
        // Late ready after release must be ignored; pipeline advances from NOPs.
        apply('{a_i, 0, 1, 1, 0, 0, a_i, 0, 0, 0}, 301);
        apply('{b_i, 0, 0, 1, 0, 0, b_i, a_i, 0, 0}, 302);
        apply('{b_i, 0, 0, 1, 0, 0, b_i, b_i, a_i, 0}, 303);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ir_pipeline_ctrl.md
IR_PIPELINE_CTRL -- requirements
Module: ir_pipeline_ctrl

Interface
REQ-001 Parameter NOP_IR, default 32'h0000_0000, instruction word injected as a bubble.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; all registers cleared while low.
REQ-004 fetch_ir  input  32  instruction from instruction memory at current PC.
REQ-005 branch_taken  input  1  X-stage branch/jump resolved taken; flush younger stages.
REQ-006 multdiv_ready  input  1  multiplier/divider result valid (one-cycle pulse).
REQ-007 fd_ir, dx_ir, xm_ir, mw_ir  output  32 each  F/D, D/X, X/M, M/W instruction registers; dx/xm/mw feed the bypass control stage.
REQ-008 pc_enable  output  1  high when PC and fd_ir may advance.
REQ-009 multdiv_start  output  1  one-cycle pulse launching mul/div of the op in dx_ir.
REQ-010 md_busy  output  1  high while in MD_WAIT.

Function
REQ-011 Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
REQ-012 Mul/div in DX: opcode 00000 and ALU op 00110 (mul) or 00111 (div).
REQ-013 FD source A: bits[26:22] if opcode 00100 (jr); 5'd30 if opcode 10110 (bex); else rs.
REQ-014 FD source B: rt if opcode 00000; bits[26:22] for opcodes 00111, 00010, 00110; otherwise unused.
REQ-015 Load-use hazard: dx opcode 01000, dx rd != 0, and rd equals a used FD source; for FD opcode 00111 only source A counts (store data served by W->M bypass).
REQ-016 State machine md_state: MD_IDLE, MD_START, MD_WAIT; reset to MD_IDLE.
REQ-017 MD_IDLE -> MD_START when dx_ir is mul/div; MD_START -> MD_WAIT unconditionally; MD_WAIT -> MD_IDLE on multdiv_ready.
REQ-018 multdiv_start high exactly during MD_START; md_busy high exactly during MD_WAIT.
REQ-019 Each edge, one action by priority: (1) md hold, (2) flush, (3) load-use stall, (4) advance.
REQ-020 Md hold (DX mul/div and not [MD_WAIT with multdiv_ready]): fd_ir, dx_ir hold; xm_ir <= NOP_IR; mw_ir <= xm_ir; pc_enable low.
REQ-021 Md completion (MD_WAIT and multdiv_ready): full advance per REQ-024; mul/div moves to xm_ir in that edge.
REQ-022 Flush (branch_taken, no md hold): fd_ir <= NOP_IR, dx_ir <= NOP_IR, xm_ir <= dx_ir, mw_ir <= xm_ir; pc_enable high.
REQ-023 Load-use stall: fd_ir holds, dx_ir <= NOP_IR, xm_ir <= dx_ir, mw_ir <= xm_ir; pc_enable low; stall lasts exactly one cycle.
REQ-024 Advance: fd_ir <= fetch_ir, dx_ir <= fd_ir, xm_ir <= dx_ir, mw_ir <= xm_ir; pc_enable high.
REQ-025 pc_enable is combinational from current registers/inputs, valid same cycle.
REQ-026 branch_taken during md hold is ignored (no branch can occupy X then).
REQ-027 multdiv_ready outside MD_WAIT is ignored.
REQ-028 mw_ir always receives xm_ir each edge (M/W never stalls).

Reset
REQ-029 While reset low: fd_ir, dx_ir, xm_ir, mw_ir = NOP_IR; md_state = MD_IDLE; multdiv_start = 0; md_busy = 0.
REQ-030 Reset asserted mid-MD_WAIT aborts the operation; after release, pipeline resumes with advance from NOP state.
REQ-031 pc_enable = 1 while in reset.

Verification
REQ-032 Straight-line: fetch addi r1,r0,5 then add r2,r1,r1 -> appear in dx_ir, xm_ir, mw_ir on successive edges; pc_enable constant 1.
REQ-033 Load-use: dx_ir = lw r3,0(r0), fd_ir = add r4,r3,r0 -> one edge with dx_ir = 0, fd_ir held, pc_enable 0 for 1 cycle; no stall when fd_ir = sw r3,0(r5) or lw rd = r0.
REQ-034 Branch: branch_taken with fd_ir/dx_ir nonzero -> next edge both 0, xm_ir = prior dx_ir; flush wins over simultaneous load-use hazard.
REQ-035 Mul: dx_ir = mul r5,r1,r2, multdiv_ready after 4 cycles in MD_WAIT -> multdiv_start single pulse, md_busy 4 cycles, xm_ir = 0 each hold cycle, mul enters xm_ir on ready edge.
REQ-036 Reset low during MD_WAIT -> all IRs 0, md_busy 0 immediately; late multdiv_ready after release ignored.
